// File: rtl/anita_evbuf_pkg.sv
// Shared constants and helpers for the ANITA multi-event buffer.
package anita_evbuf_pkg;

  // Width of the clear-strobe counter.
  localparam int CLEAR_CNT_W = 8;

  // Bit positions of the fields inside status_o.
  localparam int STAT_ACTIVE_LSB = 0;
  localparam int STAT_ACTIVE_W   = 16;
  localparam int STAT_CLR_LSB    = 16;
  localparam int STAT_VALID_BIT  = 24;
  localparam int STAT_FULL_BIT   = 25;
  localparam int STAT_OVF_BIT    = 26;
  localparam int STAT_COUNT_LSB  = 27;
  localparam int STAT_COUNT_W    = 5;

  // Ceiling log2, usable in parameter expressions; clog2(1) is 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/anita_event_order_fifo.sv
// Completion-order queue of buffer indices with first-word-fall-through head.
module anita_event_order_fifo
  import anita_evbuf_pkg::*;
#(
  parameter  int W     = 2,
  parameter  int DEPTH = 4,
  localparam int AW    = clog2(DEPTH),
  localparam int CNT_W = AW + 1
) (
  input  logic             clk33_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [W-1:0]     push_dat_i,
  input  logic             pop_i,
  output logic [W-1:0]     head_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CNT_W-1:0] count_o
);

  logic [W-1:0]     r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty_o   = (r_count == '0);
  assign full_o    = (r_count == CNT_W'(DEPTH));
  assign w_do_pop  = pop_i && !empty_o;
  // A pop frees a slot in the same edge, so a full queue still takes a push.
  assign w_do_push = push_i && (!full_o || w_do_pop);
  assign head_o    = empty_o ? '0 : r_mem[r_rd_ptr];
  assign count_o   = r_count;

  // Entry storage, written at the tail.
  // NOTE: storage is deliberately not reset; pointers and count define which entries are live.
  always_ff @(posedge clk33_i) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_dat_i;
  end

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk33_i) begin
    if (rst_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/anita_multi_event_buffer.sv
// NBUF event buffers in one RAM, released to readout in strict completion order.
module anita_multi_event_buffer
  import anita_evbuf_pkg::*;
#(
  parameter  int NBUF             = 4,
  parameter  int BUF_AW           = 6,
  parameter  int CLEARS_PER_EVENT = 2,
  localparam int BW               = clog2(NBUF),
  localparam int WR_AW            = BW + BUF_AW + 1,
  localparam int CNT_W            = BW + 1
) (
  input  logic              clk33_i,
  input  logic              rst_i,
  input  logic [WR_AW-1:0]  event_wr_addr_i,
  input  logic [15:0]       event_wr_dat_i,
  input  logic              event_wr_i,
  input  logic              event_done_i,
  input  logic [BUF_AW-1:0] event_rd_addr_i,
  output logic [31:0]       event_rd_dat_o,
  output logic [BW-1:0]     read_buffer_o,
  output logic              buffer_valid_o,
  input  logic              clear_evt_i,
  output logic              clear_done_o,
  output logic [NBUF-1:0]   buffer_active_o,
  output logic              full_o,
  output logic              overflow_o,
  output logic [31:0]       status_o
);

  localparam int RD_DEPTH = NBUF << BUF_AW;

  logic [31:0]            r_ram [RD_DEPTH];
  logic [31:0]            r_rd_dat;
  logic [NBUF-1:0]        r_active;
  logic [CLEAR_CNT_W-1:0] r_clr_cnt;
  logic                   r_overflow;
  logic                   r_clear_done;

  logic [BW-1:0]          w_head;
  logic                   w_empty;
  logic                   w_full;
  logic [CNT_W-1:0]       w_count;
  logic                   w_valid;
  logic [BW-1:0]          w_done_buf;
  logic                   w_accept;
  logic                   w_clear_hit;
  logic                   w_release;
  logic [WR_AW-2:0]       w_rd_addr;

  assign w_valid     = !w_empty;
  assign w_done_buf  = event_wr_addr_i[WR_AW-1 -: BW];
  // Both acceptance conditions look at pre-edge state, so a done for the buffer
  // being released in the same cycle is still seen as active and rejected.
  assign w_accept    = event_done_i && !r_active[w_done_buf] && !w_full;
  assign w_clear_hit = clear_evt_i && w_valid;
  assign w_release   = w_clear_hit && (r_clr_cnt == CLEAR_CNT_W'(CLEARS_PER_EVENT - 1));
  assign w_rd_addr   = {w_head, event_rd_addr_i};

  anita_event_order_fifo #(
    .W     (BW),
    .DEPTH (NBUF)
  ) u_order_fifo (
    .clk33_i    (clk33_i),
    .rst_i      (rst_i),
    .push_i     (w_accept),
    .push_dat_i (w_done_buf),
    .pop_i      (w_release),
    .head_o     (w_head),
    .empty_o    (w_empty),
    .full_o     (w_full),
    .count_o    (w_count)
  );

  // Event RAM: 16-bit write halves of a 32-bit word; even write address fills the low half.
  always_ff @(posedge clk33_i) begin
    if (event_wr_i) begin
      if (event_wr_addr_i[0]) r_ram[event_wr_addr_i[WR_AW-1:1]][31:16] <= event_wr_dat_i;
      else                    r_ram[event_wr_addr_i[WR_AW-1:1]][15:0]  <= event_wr_dat_i;
    end
  end

  // Registered read port addressing the current head buffer.
  always_ff @(posedge clk33_i) begin
    if (rst_i) r_rd_dat <= '0;
    else       r_rd_dat <= r_ram[w_rd_addr];
  end

  // Occupancy flags: set on an accepted done, cleared on release of the head.
  always_ff @(posedge clk33_i) begin
    if (rst_i) begin
      r_active <= '0;
    end else begin
      if (w_release) r_active[w_head]     <= 1'b0;
      if (w_accept)  r_active[w_done_buf] <= 1'b1;
    end
  end

  // Clear-strobe counting, sticky overflow and the release-acknowledge pulse.
  always_ff @(posedge clk33_i) begin
    if (rst_i) begin
      r_clr_cnt    <= '0;
      r_overflow   <= 1'b0;
      r_clear_done <= 1'b0;
    end else begin
      if (w_release)        r_clr_cnt <= '0;
      else if (w_clear_hit) r_clr_cnt <= r_clr_cnt + CLEAR_CNT_W'(1);
      if (event_done_i && !w_accept) r_overflow <= 1'b1;
      r_clear_done <= w_release;
    end
  end

  assign event_rd_dat_o  = r_rd_dat;
  assign read_buffer_o   = w_head;
  assign buffer_valid_o  = w_valid;
  assign clear_done_o    = r_clear_done;
  assign buffer_active_o = r_active;
  assign full_o          = w_full;
  assign overflow_o      = r_overflow;

  // Packed status word for the register interface.
  // NOTE: the whole word gets a default first so no bit can infer a latch.
  always_comb begin
    status_o = '0;
    status_o[STAT_ACTIVE_LSB +: NBUF]       = r_active;
    status_o[STAT_CLR_LSB +: CLEAR_CNT_W]   = r_clr_cnt;
    status_o[STAT_VALID_BIT]                = w_valid;
    status_o[STAT_FULL_BIT]                 = w_full;
    status_o[STAT_OVF_BIT]                  = r_overflow;
    status_o[STAT_COUNT_LSB +: CNT_W]       = w_count;
  end

endmodule

// File: tb/tb_anita_multi_event_buffer.sv
// Bench for anita_multi_event_buffer: two instances (2 clears and 1 clear per event)
// share stimulus and are each compared every cycle against a queue-level model.
module tb_anita_multi_event_buffer;

  localparam int NB = 4;
  localparam int AW = 6;
  localparam int BW = 2;
  localparam int WA = BW + AW + 1;
  localparam int NWORD16 = 1 << WA;

  logic          clk;
  logic          rst;
  logic [WA-1:0] wr_addr;
  logic [15:0]   wr_dat;
  logic          wr;
  logic          done;
  logic [AW-1:0] rd_addr;
  logic          clr;

  logic [31:0]   rd_dat [2];
  logic [BW-1:0] rb     [2];
  logic          valid  [2];
  logic          cd     [2];
  logic [NB-1:0] act    [2];
  logic          full   [2];
  logic          ovf    [2];
  logic [31:0]   status [2];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  // Model state, one set per instance.
  int          c_of [2] = '{2, 1};
  int          mq   [2][NB];
  int          mcnt [2];
  bit          mact [2][NB];
  int          mclr [2];
  bit          movf [2];
  bit          mcd  [2];
  logic [31:0] mrd  [2];
  bit          mrd_known [2];
  logic [15:0] mem  [NWORD16];
  bit          known[NWORD16];

  anita_multi_event_buffer #(.NBUF(NB), .BUF_AW(AW), .CLEARS_PER_EVENT(2)) u_dut0 (
    .clk33_i(clk), .rst_i(rst), .event_wr_addr_i(wr_addr), .event_wr_dat_i(wr_dat),
    .event_wr_i(wr), .event_done_i(done), .event_rd_addr_i(rd_addr),
    .event_rd_dat_o(rd_dat[0]), .read_buffer_o(rb[0]), .buffer_valid_o(valid[0]),
    .clear_evt_i(clr), .clear_done_o(cd[0]), .buffer_active_o(act[0]),
    .full_o(full[0]), .overflow_o(ovf[0]), .status_o(status[0])
  );

  anita_multi_event_buffer #(.NBUF(NB), .BUF_AW(AW), .CLEARS_PER_EVENT(1)) u_dut1 (
    .clk33_i(clk), .rst_i(rst), .event_wr_addr_i(wr_addr), .event_wr_dat_i(wr_dat),
    .event_wr_i(wr), .event_done_i(done), .event_rd_addr_i(rd_addr),
    .event_rd_dat_o(rd_dat[1]), .read_buffer_o(rb[1]), .buffer_valid_o(valid[1]),
    .clear_evt_i(clr), .clear_done_o(cd[1]), .buffer_active_o(act[1]),
    .full_o(full[1]), .overflow_o(ovf[1]), .status_o(status[1])
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic int m_head(input int k);
    return (mcnt[k] > 0) ? mq[k][0] : 0;
  endfunction

  function automatic logic [31:0] m_status(input int k);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < NB; i++) s[i] = mact[k][i];
    s[23:16] = mclr[k][7:0];
    s[24]    = (mcnt[k] > 0);
    s[25]    = (mcnt[k] == NB);
    s[26]    = movf[k];
    s[31:27] = mcnt[k][4:0];
    return s;
  endfunction

  // Advance the model by one clock edge using the inputs presented to that edge.
  task automatic model_update();
    int  b, head, lo, hi;
    bit  is_valid, rel, acc;
    b = int'(wr_addr[WA-1 -: BW]);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mcnt[k] = 0; mclr[k] = 0; movf[k] = 0; mcd[k] = 0;
        for (int i = 0; i < NB; i++) mact[k][i] = 0;
        mrd[k] = '0; mrd_known[k] = 1;
      end else begin
        head     = m_head(k);
        is_valid = (mcnt[k] > 0);
        lo  = (head * (1 << AW) + int'(rd_addr)) * 2;
        hi  = lo + 1;
        mrd[k]       = {mem[hi], mem[lo]};
        mrd_known[k] = known[lo] && known[hi] &&
                       !(wr && (int'(wr_addr) == lo || int'(wr_addr) == hi));
        rel = clr && is_valid && (mclr[k] == c_of[k] - 1);
        acc = done && !mact[k][b] && (mcnt[k] < NB);
        if (clr && is_valid) mclr[k] = rel ? 0 : mclr[k] + 1;
        if (done && !acc) movf[k] = 1;
        if (rel) begin
          for (int i = 0; i < NB - 1; i++) mq[k][i] = mq[k][i+1];
          mcnt[k]--;
          mact[k][head] = 0;
        end
        if (acc) begin
          mq[k][mcnt[k]] = b;
          mcnt[k]++;
          mact[k][b] = 1;
        end
        mcd[k] = rel;
      end
    end
    if (wr) begin
      mem[int'(wr_addr)]   = wr_dat;
      known[int'(wr_addr)] = 1;
    end
  endtask

  // One clock: edge, model update, then strobes drop 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    wr = 0; done = 0; clr = 0; rst = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    step();
  endtask

  task automatic do_done(input int b);
    wr_addr = {BW'(b), 7'd0};
    done    = 1;
    step();
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("u%0d read_buffer", k), 32'(rb[k]), 32'(m_head(k)));
        check($sformatf("u%0d valid", k), 32'(valid[k]), 32'(mcnt[k] > 0));
        check($sformatf("u%0d clear_done", k), 32'(cd[k]), 32'(mcd[k]));
        check($sformatf("u%0d full", k), 32'(full[k]), 32'(mcnt[k] == NB));
        check($sformatf("u%0d overflow", k), 32'(ovf[k]), 32'(movf[k]));
        check($sformatf("u%0d status", k), status[k], m_status(k));
        check($sformatf("u%0d active", k), 32'(act[k]), m_status(k) & 32'hF);
        if (mrd_known[k]) check($sformatf("u%0d rd_dat", k), rd_dat[k], mrd[k]);
      end
    end
  end

  initial begin
    int exp_rb [4];
    rst = 1; wr = 0; done = 0; clr = 0; wr_addr = '0; wr_dat = '0; rd_addr = '0;
    for (int i = 0; i < NWORD16; i++) known[i] = 0;
    step();
    do_reset();
    chk_en = 1;

    // Reset state.
    check("reset status", status[0], 32'h0);
    check("reset valid", 32'(valid[0]), 32'h0);
    check("reset rd_dat", rd_dat[0], 32'h0);

    // Done on buffers 2, 0, 3.
    do_done(2); do_done(0); do_done(3);
    check("order head", 32'(rb[0]), 32'd2);
    check("order active", 32'(act[0]), 32'b1101);
    check("order count", 32'(status[0][31:27]), 32'd3);
    check("order valid", 32'(valid[0]), 32'd1);

    // Four clears with two clears per event.
    exp_rb = '{2, 0, 0, 3};
    for (int i = 0; i < 4; i++) begin
      clr = 1;
      step();
      check($sformatf("clear%0d pulse", i), 32'(cd[0]), 32'((i % 2) == 1));
      check($sformatf("clear%0d head", i), 32'(rb[0]), 32'(exp_rb[i]));
    end
    check("clears active", 32'(act[0]), 32'b1000);

    // RAM write/read through the head buffer.
    do_reset();
    wr = 1; wr_addr = {2'd1, 7'd0}; wr_dat = 16'hAAAA; step();
    wr = 1; wr_addr = {2'd1, 7'd1}; wr_dat = 16'h5555; step();
    do_done(1);
    rd_addr = '0;
    step();
    check("ram read u0", rd_dat[0], 32'h5555AAAA);
    check("ram read u1", rd_dat[1], 32'h5555AAAA);

    // Duplicate done rejected; overflow sticky through clears, cleared by reset.
    do_done(1);
    check("dup overflow", 32'(ovf[0]), 32'd1);
    check("dup count", 32'(status[0][31:27]), 32'd1);
    clr = 1; step();
    clr = 1; step();
    check("ovf after clears", 32'(ovf[0]), 32'd1);
    check("empty after clears", 32'(valid[0]), 32'd0);
    do_reset();
    check("ovf after reset", 32'(ovf[0]), 32'd0);

    // Single-clear instance: full queue, then done racing a release.
    do_done(0); do_done(1); do_done(2); do_done(3);
    check("u1 full", 32'(full[1]), 32'd1);
    wr_addr = {2'd0, 7'd0}; done = 1; clr = 1; step();
    check("u1 head-done ovf", 32'(ovf[1]), 32'd1);
    check("u1 head-done count", 32'(status[1][31:27]), 32'd3);
    check("u1 head-done active", 32'(act[1]), 32'b1110);
    wr_addr = {2'd0, 7'd0}; done = 1; clr = 1; step();
    check("u1 swap count", 32'(status[1][31:27]), 32'd3);
    check("u1 swap head", 32'(rb[1]), 32'd2);
    check("u1 swap active", 32'(act[1]), 32'b1101);

    // Clear with an empty queue is ignored.
    do_reset();
    clr = 1; step();
    check("empty clr count", 32'(status[0][23:16]), 32'd0);
    check("empty clr pulse u0", 32'(cd[0]), 32'd0);
    check("empty clr pulse u1", 32'(cd[1]), 32'd0);

    // Reset while buffers are queued.
    do_done(0); do_done(1);
    clr = 1; step();
    do_reset();
    check("midrst status", status[0], 32'h0);
    check("midrst head", 32'(rb[0]), 32'd0);
    check("midrst valid", 32'(valid[0]), 32'd0);
    check("midrst flags", 32'({full[0], ovf[0], cd[0]}), 32'd0);
    check("midrst rd_dat", rd_dat[0], 32'h0);

    // Randomised traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      wr      = ($urandom_range(0, 1) == 1);
      wr_dat  = 16'($urandom);
      wr_addr = WA'($urandom);
      if ($urandom_range(0, 1) == 1) wr_addr[AW:0] = (AW+1)'($urandom_range(0, 7));
      done    = ($urandom_range(0, 3) == 0);
      clr     = ($urandom_range(0, 2) == 0);
      rd_addr = AW'($urandom_range(0, 3));
      rst     = ($urandom_range(0, 299) == 0);
      step();
    end

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
